uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised successor to the team's single-format UART transmitter. It serialises one DATA_W-bit word per frame: start bit, data LSB first, optional parity, then 1 or 2 stop bits. Bit timing comes from an external one-clk-wide baud tick. It sits between the TX FIFO (valid/ready handshake) and the tx pin. Frames can run back-to-back, and the line idles high.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9
PARITY, 1, parity mode: 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; legal 1 or 2

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  reset; asynchronous, active-low (0 = in reset)
baud_clk  in  1  baud tick; one-clk-wide pulse per bit period, synchronous to clk
wr_en  in  1  valid from the TX FIFO; a word transfers when wr_en && ready at a clk edge
data_in  in  DATA_W  word to send; sampled only on transfer
ready  out  1  block can accept a word this cycle
busy  out  1  a frame is loaded or in progress
done_tx  out  1  one-clk pulse when the last stop bit completes
tx_out  out  1  serial line, registered, idle high

Behaviour:
- Reset (rst=0, async): tx_out=1, done_tx=0, busy=0, ready=1, state IDLE, pending flag cleared. Reset mid-frame aborts the frame; the line returns high immediately. No done_tx pulse is issued for the aborted frame.
- States: IDLE, ARM, START, DATA, PARITY, STOP. All transitions out of ARM and later states occur only on cycles with baud_clk=1.
- IDLE: tx_out=1, ready=1, busy=0. On transfer: latch data_in, compute parity, go to ARM.
- Parity bit: even = XOR of data; odd = XNOR of data. Computed at latch time from the latched word.
- ARM: tx_out=1, ready=0, busy=1. On a tick, go to START. This aligns the start bit to the tick grid so every bit lasts exactly one tick period.
- START: tx_out=0. On a tick, go to DATA with bit index = 0.
- DATA: tx_out = data[idx], LSB first. On a tick:
  - if idx = DATA_W-1, go to PARITY when PARITY != 0, else go to STOP;
  - otherwise increment idx.
  - idx is $clog2(DATA_W) bits wide and never wraps.
- PARITY: tx_out = parity bit. On a tick, go to STOP with stop count = 0.
- STOP: tx_out=1. On a tick:
  - if this is not the last stop bit, increment the stop count;
  - if it is the last stop bit: done_tx=1 for exactly that clk cycle, then go to START if a word is pending, else IDLE.
- Back-to-back: during the last stop bit, ready=1 until one word has been accepted.
  - A word accepted then sets the pending flag and is latched into the shift register.
  - START follows the terminating tick with no idle gap.
- Simultaneous wr_en with the terminating tick in the last stop bit: the word is accepted and treated as pending. The next frame starts with no gap.
- tx_out is driven straight from a flop and never goes X.
- baud_clk=1 while in IDLE has no effect.
- data_in changing after transfer does not affect the frame in flight.
- Frame length in ticks: 1 + DATA_W + (PARITY != 0) + STOP_BITS. ARM adds a 0..1 tick alignment delay before the first frame only.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input port send_break (1 bit).
  - send_break=1 in IDLE with ready=1 starts a break; send_break has priority over wr_en in the same cycle.
  - Break sequence: ARM, then tx_out=0 for 1 + DATA_W + (PARITY != 0) + STOP_BITS ticks, then tx_out=1 for one tick.
  - done_tx pulses at the end of the break. busy=1 and ready=0 throughout.
- Undefined: no send_break port. tx_out is low only during start, data or parity bits.

Test Plan:
- DATA_W=8, PARITY=1, STOP_BITS=1, tick every 16 clk, send 0xA5 -> tx_out per tick: 0, 1,0,1,0,0,1,0,1, 0 (parity), 1. done_tx pulses once on the 11th tick after ARM. Then ready=1, busy=0.
- PARITY=2, send 0x01 -> parity bit 0. Send 0x03 -> parity bit 1. PARITY=0 -> frame is 10 ticks with no parity slot.
- DATA_W=7, STOP_BITS=2, send 0x7F -> 0, seven 1s, parity (even) 1, then tx_out=1 for 2 ticks. done_tx only after the second stop tick.
- Back-to-back: hold wr_en=1 with 0x55 then 0xAA -> the second start bit follows the first stop bit on the very next tick. Two done_tx pulses 11 ticks apart.
- Assert rst=0 mid-DATA (bit 3 of 0x00) -> tx_out=1 in the same cycle, no done_tx. After release: ready=1, and a new frame transmits correctly.
- With UART_TX_BREAK_EN defined and PARITY=1: send_break=1 in IDLE -> tx_out=0 for 11 ticks, then 1 for 1 tick, then done_tx. wr_en asserted in the same cycle is not accepted.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter (DATA_W/PARITY/STOP_BITS), tick-paced, back-to-back frames
// Optional UART_TX_BREAK_EN adds a send_break input that emits a full-frame-length break.
module uart_tx_cfg #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_clk,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
`ifdef UART_TX_BREAK_EN
  input  logic              send_break,
`endif
  output logic              ready,
  output logic              busy,
  output logic              done_tx,
  output logic              tx_out
);

  localparam int                IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic              PAR_EN   = (PARITY != 0);
  localparam logic              PAR_ODD  = (PARITY == 2);
  localparam logic              STOP_TWO = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BRK_LOW, S_BRK_HIGH
`endif
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic              stop_cnt;
  logic              pending;
  logic              accept;
  logic              par_in;

`ifdef UART_TX_BREAK_EN
  localparam int         FRAME_TICKS = 1 + DATA_W + int'(PAR_EN) + STOP_BITS;
  localparam logic [3:0] BRK_LAST    = 4'(FRAME_TICKS - 1);
  logic       brk_mode;
  logic [3:0] brk_cnt;
  // a break request in IDLE wins over a simultaneous word
  assign accept = wr_en && ready && !((state == S_IDLE) && send_break);
`else
  assign accept = wr_en && ready;
`endif

  assign par_in  = (^data_in) ^ PAR_ODD;
  assign idx_nxt = idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      tx_out   <= 1'b1;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done_tx  <= 1'b0;
      pending  <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      idx      <= '0;
      stop_cnt <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_mode <= 1'b0;
      brk_cnt  <= '0;
`endif
    end else begin
      done_tx <= 1'b0;
      if (accept) begin
        shreg   <= data_in;
        par_bit <= par_in;
      end
      case (state)
        S_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (send_break) begin
            state    <= S_ARM;
            brk_mode <= 1'b1;
            ready    <= 1'b0;
            busy     <= 1'b1;
          end else
`endif
          if (wr_en) begin
            state <= S_ARM;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_ARM: begin
          if (baud_clk) begin
            tx_out <= 1'b0;
`ifdef UART_TX_BREAK_EN
            if (brk_mode) begin
              state   <= S_BRK_LOW;
              brk_cnt <= '0;
            end else
`endif
            state <= S_START;
          end
        end
        S_START: begin
          if (baud_clk) begin
            state  <= S_DATA;
            idx    <= '0;
            tx_out <= shreg[0];
          end
        end
        S_DATA: begin
          if (baud_clk) begin
            if (idx == IDX_LAST) begin
              if (PAR_EN) begin
                state  <= S_PARITY;
                tx_out <= par_bit;
              end else begin
                state    <= S_STOP;
                tx_out   <= 1'b1;
                stop_cnt <= 1'b0;
                ready    <= !STOP_TWO;
              end
            end else begin
              idx    <= idx_nxt;
              tx_out <= shreg[idx_nxt];
            end
          end
        end
        S_PARITY: begin
          if (baud_clk) begin
            state    <= S_STOP;
            tx_out   <= 1'b1;
            stop_cnt <= 1'b0;
            ready    <= !STOP_TWO;
          end
        end
        S_STOP: begin
          // ready is only high in the last stop bit, so this is the follow-on word
          if (accept) begin
            pending <= 1'b1;
            ready   <= 1'b0;
          end
          if (baud_clk) begin
            if (STOP_TWO && !stop_cnt) begin
              stop_cnt <= 1'b1;
              ready    <= 1'b1;
            end else begin
              done_tx <= 1'b1;
              if (pending || accept) begin
                state   <= S_START;
                tx_out  <= 1'b0;
                pending <= 1'b0;
                ready   <= 1'b0;
              end else begin
                state <= S_IDLE;
                ready <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        S_BRK_LOW: begin
          if (baud_clk) begin
            if (brk_cnt == BRK_LAST) begin
              state  <= S_BRK_HIGH;
              tx_out <= 1'b1;
            end else begin
              brk_cnt <= brk_cnt + 1'b1;
            end
          end
        end
        S_BRK_HIGH: begin
          if (baud_clk) begin
            done_tx  <= 1'b1;
            state    <= S_IDLE;
            ready    <= 1'b1;
            busy     <= 1'b0;
            brk_mode <= 1'b0;
          end
        end
`endif
        default: begin
          state  <= S_IDLE;
          tx_out <= 1'b1;
          ready  <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg over four parameter sets
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud = 1'b0;
  logic [3:0] bcnt = 4'd0;
  logic [3:0] wr = 4'd0;
  logic [3:0] tx, rdy, bsy, dn;
  logic [7:0] d8 = 8'd0;
  logic [6:0] d7 = 7'd0;
  logic [1:0] sel = 2'd0;
`ifdef UART_TX_BREAK_EN
  logic [3:0] brk = 4'd0;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int done_seen = 0;

  logic tx_m, rdy_m, bsy_m, dn_m;
  assign tx_m  = tx[sel];
  assign rdy_m = rdy[sel];
  assign bsy_m = bsy[sel];
  assign dn_m  = dn[sel];

  always #5 clk = ~clk;

  // baud tick: one clk wide, every 16 clk
  always @(posedge clk) begin
    bcnt <= bcnt + 4'd1;
    baud <= (bcnt == 4'd14);
  end

  uart_tx_cfg #(.DATA_W(8), .PARITY(1), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .baud_clk(baud), .wr_en(wr[0]), .data_in(d8),
`ifdef UART_TX_BREAK_EN
    .send_break(brk[0]),
`endif
    .ready(rdy[0]), .busy(bsy[0]), .done_tx(dn[0]), .tx_out(tx[0]));

  uart_tx_cfg #(.DATA_W(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .baud_clk(baud), .wr_en(wr[1]), .data_in(d8),
`ifdef UART_TX_BREAK_EN
    .send_break(brk[1]),
`endif
    .ready(rdy[1]), .busy(bsy[1]), .done_tx(dn[1]), .tx_out(tx[1]));

  uart_tx_cfg #(.DATA_W(8), .PARITY(0), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .baud_clk(baud), .wr_en(wr[2]), .data_in(d8),
`ifdef UART_TX_BREAK_EN
    .send_break(brk[2]),
`endif
    .ready(rdy[2]), .busy(bsy[2]), .done_tx(dn[2]), .tx_out(tx[2]));

  uart_tx_cfg #(.DATA_W(7), .PARITY(1), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .baud_clk(baud), .wr_en(wr[3]), .data_in(d7),
`ifdef UART_TX_BREAK_EN
    .send_break(brk[3]),
`endif
    .ready(rdy[3]), .busy(bsy[3]), .done_tx(dn[3]), .tx_out(tx[3]));

  task automatic wait_tick();
    int guard = 0;
    do begin
      @(negedge clk);
      if (dn_m) done_seen++;
      guard++;
    end while (!baud && guard < 64);
    if (!baud) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout: no baud tick within %0d cycles, required one", guard);
    end
  endtask

  task automatic capture(input int n, output logic [15:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      wait_tick();
      bits[i] = tx_m;
    end
  endtask

  task automatic send(input logic [1:0] s, input logic [7:0] v);
    sel = s;
    @(negedge clk);
    if (s == 2'd3) d7 = v[6:0];
    else d8 = v;
    wr[s] = 1'b1;
    @(posedge clk);
    #1 wr[s] = 1'b0;
  endtask

  task automatic test_reset();
    logic idle_bad;
    sel = 2'd0;
    @(negedge clk);
    n_checks++;
    if (tx !== 4'hF) begin n_fail++; $display("FAIL reset_tx: got %b, required 1111", tx); end
    n_checks++;
    if (rdy !== 4'hF || bsy !== 4'h0 || dn !== 4'h0) begin
      n_fail++; $display("FAIL reset_flags: ready=%b busy=%b done=%b, required 1111/0000/0000", rdy, bsy, dn);
    end
    rst = 1'b1;
    idle_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_m !== 1'b1 || bsy_m !== 1'b0 || rdy_m !== 1'b1) idle_bad = 1'b1;
    end
    n_checks++;
    if (idle_bad !== 1'b0) begin n_fail++; $display("FAIL idle_ticks: idle disturbed by baud ticks, got 1 required 0"); end
  endtask

  task automatic test_even();
    logic [15:0] a;
    send(2'd0, 8'hA5);
    d8 = 8'hFF;
    done_seen = 0;
    wait_tick();
    n_checks++;
    if ({tx_m, rdy_m, bsy_m} !== 3'b101) begin
      n_fail++; $display("FAIL arm_state: tx/ready/busy=%b%b%b, required 101", tx_m, rdy_m, bsy_m);
    end
    capture(11, a);
    n_checks++;
    if (a[10:0] !== 11'h54A) begin n_fail++; $display("FAIL even_a5_frame: got %h, required 54a", a[10:0]); end
    n_checks++;
    if (done_seen !== 0) begin n_fail++; $display("FAIL even_early_done: got %0d pulses, required 0", done_seen); end
    @(negedge clk);
    n_checks++;
    if ({dn_m, rdy_m, bsy_m} !== 3'b110) begin
      n_fail++; $display("FAIL even_done: done/ready/busy=%b%b%b, required 110", dn_m, rdy_m, bsy_m);
    end
    @(negedge clk);
    n_checks++;
    if (dn_m !== 1'b0) begin n_fail++; $display("FAIL even_done_width: got %b, required 0", dn_m); end
  endtask

  task automatic test_odd();
    logic [15:0] a;
    send(2'd1, 8'h01);
    wait_tick();
    capture(11, a);
    n_checks++;
    if (a[10:0] !== 11'h402) begin n_fail++; $display("FAIL odd_01_frame: got %h, required 402", a[10:0]); end
    @(negedge clk);
    n_checks++;
    if (dn_m !== 1'b1) begin n_fail++; $display("FAIL odd_01_done: got %b, required 1", dn_m); end
    send(2'd1, 8'h03);
    wait_tick();
    capture(11, a);
    n_checks++;
    if (a[10:0] !== 11'h606) begin n_fail++; $display("FAIL odd_03_frame: got %h, required 606", a[10:0]); end
  endtask

  task automatic test_no_parity();
    logic [15:0] a;
    send(2'd2, 8'h3C);
    done_seen = 0;
    wait_tick();
    capture(10, a);
    n_checks++;
    if (a[9:0] !== 10'h278) begin n_fail++; $display("FAIL nopar_frame: got %h, required 278", a[9:0]); end
    @(negedge clk);
    n_checks++;
    if ({dn_m, rdy_m, bsy_m} !== 3'b110) begin
      n_fail++; $display("FAIL nopar_len: done/ready/busy=%b%b%b, required 110", dn_m, rdy_m, bsy_m);
    end
  endtask

  task automatic test_two_stop();
    logic [15:0] a, b, c;
    send(2'd3, 8'h7F);
    done_seen = 0;
    wait_tick();
    capture(9, a);
    @(negedge clk);
    n_checks++;
    if (rdy_m !== 1'b0) begin n_fail++; $display("FAIL stop1_ready: got %b, required 0", rdy_m); end
    capture(1, b);
    @(negedge clk);
    n_checks++;
    if (rdy_m !== 1'b1) begin n_fail++; $display("FAIL stop2_ready: got %b, required 1", rdy_m); end
    capture(1, c);
    n_checks++;
    if ({c[0], b[0], a[8:0]} !== 11'h7FE) begin
      n_fail++; $display("FAIL two_stop_frame: got %h, required 7fe", {c[0], b[0], a[8:0]});
    end
    n_checks++;
    if (done_seen !== 0) begin n_fail++; $display("FAIL two_stop_early_done: got %0d, required 0", done_seen); end
    @(negedge clk);
    n_checks++;
    if (dn_m !== 1'b1) begin n_fail++; $display("FAIL two_stop_done: got %b, required 1", dn_m); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, c;
    sel = 2'd0;
    @(negedge clk);
    d8 = 8'h55;
    wr[0] = 1'b1;
    @(posedge clk);
    #1 d8 = 8'hAA;
    done_seen = 0;
    wait_tick();
    capture(11, a);
    n_checks++;
    if (a[10:0] !== 11'h4AA) begin n_fail++; $display("FAIL b2b_first: got %h, required 4aa", a[10:0]); end
    n_checks++;
    if (done_seen !== 0) begin n_fail++; $display("FAIL b2b_done_a: got %0d, required 0", done_seen); end
    capture(1, b);
    wr[0] = 1'b0;
    n_checks++;
    if (done_seen !== 1) begin n_fail++; $display("FAIL b2b_done_b: got %0d, required 1", done_seen); end
    capture(10, c);
    n_checks++;
    if ({c[9:0], b[0]} !== 11'h554) begin n_fail++; $display("FAIL b2b_second: got %h, required 554", {c[9:0], b[0]}); end
    n_checks++;
    if (done_seen !== 1) begin n_fail++; $display("FAIL b2b_done_c: got %0d, required 1", done_seen); end
    @(negedge clk);
    n_checks++;
    if ({dn_m, bsy_m} !== 2'b10) begin n_fail++; $display("FAIL b2b_end: done/busy=%b%b, required 10", dn_m, bsy_m); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] a;
    int pulses;
    send(2'd0, 8'h00);
    wait_tick();
    capture(4, a);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (tx_m !== 1'b0) begin n_fail++; $display("FAIL mid_bit3: got %b, required 0", tx_m); end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({tx_m, rdy_m, bsy_m} !== 3'b110) begin
      n_fail++; $display("FAIL mid_reset: tx/ready/busy=%b%b%b, required 110", tx_m, rdy_m, bsy_m);
    end
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dn_m) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || rdy_m !== 1'b1) begin
      n_fail++; $display("FAIL mid_after: done pulses=%0d ready=%b, required 0 and 1", pulses, rdy_m);
    end
    send(2'd0, 8'hA5);
    wait_tick();
    capture(11, a);
    n_checks++;
    if (a[10:0] !== 11'h54A) begin n_fail++; $display("FAIL mid_new_frame: got %h, required 54a", a[10:0]); end
    @(negedge clk);
    n_checks++;
    if (dn_m !== 1'b1) begin n_fail++; $display("FAIL mid_new_done: got %b, required 1", dn_m); end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    logic [15:0] a, b;
    sel = 2'd0;
    @(negedge clk);
    brk[0] = 1'b1;
    wr[0] = 1'b1;
    d8 = 8'h12;
    @(posedge clk);
    #1 brk[0] = 1'b0;
    wr[0] = 1'b0;
    done_seen = 0;
    wait_tick();
    n_checks++;
    if ({tx_m, rdy_m, bsy_m} !== 3'b101) begin
      n_fail++; $display("FAIL brk_arm: tx/ready/busy=%b%b%b, required 101", tx_m, rdy_m, bsy_m);
    end
    capture(12, a);
    n_checks++;
    if (a[11:0] !== 12'h800) begin n_fail++; $display("FAIL brk_pattern: got %h, required 800", a[11:0]); end
    n_checks++;
    if (done_seen !== 0) begin n_fail++; $display("FAIL brk_early_done: got %0d, required 0", done_seen); end
    @(negedge clk);
    n_checks++;
    if ({dn_m, rdy_m, bsy_m} !== 3'b110) begin
      n_fail++; $display("FAIL brk_done: done/ready/busy=%b%b%b, required 110", dn_m, rdy_m, bsy_m);
    end
    capture(2, b);
    n_checks++;
    if (b[1:0] !== 2'b11 || bsy_m !== 1'b0) begin
      n_fail++; $display("FAIL brk_word_dropped: line=%b busy=%b, required 11 and 0", b[1:0], bsy_m);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_no_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
